// File: rtl/debounce_pkg.sv
// Shared types and register indices for the debounced slot-bus input core.
// Optional fall-edge capture is enabled by defining DB_FALL_EDGE_EN.
package debounce_pkg;

    // Per-bit debounce state. WAIT1/WAIT0 are the qualifying windows
    // while a new level is being proven stable.
    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } db_state_t;

    // Slot register indices, sized to match reg_addr.
    localparam logic [4:0] REG_RAW  = 5'd0;
    localparam logic [4:0] REG_DB   = 5'd1;
    localparam logic [4:0] REG_RISE = 5'd2;
    localparam logic [4:0] REG_FALL = 5'd3;

endpackage

// File: rtl/debounce_input_core_db_fsm.sv
// Single-bit debouncer: a new level is accepted only after it has been
// seen on sync_in for DB_TICKS+1 consecutive clocks (one cycle to enter
// the wait state, then DB_TICKS counted cycles). The current state is
// held in the signal 'state' so checkers can bind to it directly.
module db_fsm
    import debounce_pkg::*;
#(
    parameter int DB_TICKS = 20,
    parameter int CNT_W    = $clog2(DB_TICKS)
) (
    input  logic clk,
    input  logic reset,
    input  logic sync_in,
    output logic db_out
);

    db_state_t          state;
    db_state_t          next_state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   next_cnt;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_TICKS - 1);

    // State and stability counter registers; reset aborts any debounce.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ZERO;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // Next-state logic: any disagreement during a wait returns to the
    // old stable state, so short glitches never reach db_out.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        case (state)
            ZERO: begin
                if (sync_in) begin
                    next_state = WAIT1;
                    next_cnt   = '0;
                end
            end
            WAIT1: begin
                if (!sync_in) begin
                    next_state = ZERO;
                end else if (cnt == CNT_LAST) begin
                    next_state = ONE;
                end else begin
                    next_cnt = cnt + 1'b1;
                end
            end
            ONE: begin
                if (!sync_in) begin
                    next_state = WAIT0;
                    next_cnt   = '0;
                end
            end
            WAIT0: begin
                if (sync_in) begin
                    next_state = ONE;
                end else if (cnt == CNT_LAST) begin
                    next_state = ZERO;
                end else begin
                    next_cnt = cnt + 1'b1;
                end
            end
            default: begin
                next_state = ZERO;
                next_cnt   = '0;
            end
        endcase
    end

    // Debounced level is a decode of the registered state.
    assign db_out = (state == ONE) || (state == WAIT0);

endmodule

// File: rtl/debounce_input_core.sv
// Slot-bus input core: 2-flop synchronizer, per-bit debounce FSMs,
// sticky rise (and optionally fall) event registers with write-1-to-clear.
// Optional feature macro: DB_FALL_EDGE_EN (fall register at address 3).
// Bus semantics: rd_data is a pure combinational function of reg_addr;
// a write takes effect on the clock edge where cs && write are both high.
module debounce_input_core
    import debounce_pkg::*;
#(
    parameter int N_INPUTS = 5,
    parameter int DB_TICKS = 20,
    parameter int CNT_W    = $clog2(DB_TICKS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cs,
    input  logic                read,
    input  logic                write,
    input  logic [4:0]          reg_addr,
    input  logic [31:0]         wr_data,
    output logic [31:0]         rd_data,
    input  logic [N_INPUTS-1:0] din
);

    logic [N_INPUTS-1:0] sync_s1;
    logic [N_INPUTS-1:0] sync_s2;
    logic [N_INPUTS-1:0] db;
    logic [N_INPUTS-1:0] db_q;
    logic [N_INPUTS-1:0] rise;
    logic [N_INPUTS-1:0] rise_set;
    logic [N_INPUTS-1:0] rise_clr;
    logic                bus_wr;

    // read has no side effects and upper write bits are don't-care.
    logic unused_bits;
    assign unused_bits = ^{wr_data, read};

    assign bus_wr = cs && write;

    // Two-stage synchronizer for the asynchronous pins.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_s1 <= '0;
            sync_s2 <= '0;
        end else begin
            sync_s1 <= din;
            sync_s2 <= sync_s1;
        end
    end

    genvar g;
    generate
        for (g = 0; g < N_INPUTS; g++) begin : g_fsm
            db_fsm #(
                .DB_TICKS (DB_TICKS),
                .CNT_W    (CNT_W)
            ) u_db_fsm (
                .clk     (clk),
                .reset   (reset),
                .sync_in (sync_s2[g]),
                .db_out  (db[g])
            );
        end
    endgenerate

    assign rise_set = db & ~db_q;
    assign rise_clr = (bus_wr && reg_addr == REG_RISE) ? wr_data[N_INPUTS-1:0] : '0;

    // Delayed level and sticky rise events; a same-cycle set beats a clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            db_q <= '0;
            rise <= '0;
        end else begin
            db_q <= db;
            rise <= (rise & ~rise_clr) | rise_set;
        end
    end

`ifdef DB_FALL_EDGE_EN
    logic [N_INPUTS-1:0] fall;
    logic [N_INPUTS-1:0] fall_set;
    logic [N_INPUTS-1:0] fall_clr;

    assign fall_set = ~db & db_q;
    assign fall_clr = (bus_wr && reg_addr == REG_FALL) ? wr_data[N_INPUTS-1:0] : '0;

    // Sticky fall events; a same-cycle set beats a clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            fall <= '0;
        end else begin
            fall <= (fall & ~fall_clr) | fall_set;
        end
    end
`endif

    // Read mux; unimplemented bits and addresses read as zero.
    always_comb begin
        rd_data = '0;
        case (reg_addr)
            REG_RAW:  rd_data[N_INPUTS-1:0] = sync_s2;
            REG_DB:   rd_data[N_INPUTS-1:0] = db;
            REG_RISE: rd_data[N_INPUTS-1:0] = rise;
`ifdef DB_FALL_EDGE_EN
            REG_FALL: rd_data[N_INPUTS-1:0] = fall;
`endif
            default:  rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_debounce_input_core.sv
// Directed testbench for debounce_input_core (N_INPUTS=5, DB_TICKS=8).
// Inputs are driven and outputs sampled just after the falling edge.
module tb_debounce_input_core;

    localparam int N = 5;
    localparam int T = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs;
    logic        read;
    logic        write;
    logic [4:0]  reg_addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic [N-1:0] din;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    debounce_input_core #(
        .N_INPUTS (N),
        .DB_TICKS (T)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cs       (cs),
        .read     (read),
        .write    (write),
        .reg_addr (reg_addr),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .din      (din)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Advance n rising edges, then land on the following falling edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    // Push the expected value, read the register, pop and compare.
    task automatic expect_rd(input logic [4:0] a, input logic [31:0] e, input string tag);
        logic [31:0] x;
        exp_q.push_back(e);
        reg_addr = a;
        read     = 1'b1;
        #1;
        x = exp_q.pop_front();
        checks++;
        assert (rd_data === x) else begin
            errors++;
            $error("FAIL %s addr=%0d got=%h exp=%h", tag, a, rd_data, x);
        end
        read = 1'b0;
    endtask

    // One-cycle bus write with the given chip select.
    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic c);
        cs       = c;
        write    = 1'b1;
        reg_addr = a;
        wr_data  = d;
        @(posedge clk);
        @(negedge clk);
        cs      = 1'b0;
        write   = 1'b0;
        wr_data = '0;
    endtask

    initial begin
        reset    = 1'b1;
        cs       = 1'b0;
        read     = 1'b0;
        write    = 1'b0;
        reg_addr = '0;
        wr_data  = '0;
        din      = 5'h1F;

        // Reset held 3 cycles with all pins high
        step(1);
        for (int a = 0; a < 4; a++) expect_rd(5'(a), 32'h0, "reset_early");
        step(2);
        for (int a = 0; a < 4; a++) expect_rd(5'(a), 32'h0, "reset_late");
        reset = 1'b0;
        step(1);
        expect_rd(5'd0, 32'h0, "sync_lat1");
        step(1);
        expect_rd(5'd0, 32'h1F, "sync_lat2");

        // Return to a clean all-zero state
        din = 5'h00;
        step(3);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        for (int a = 0; a < 8; a++) expect_rd(5'(a), 32'h0, "clean_zero");

        // Clean press on bit 0: db exactly 11 edges after the pin change
        din = 5'h01;
        step(10);
        expect_rd(5'd1, 32'h00, "press_db_early");
        expect_rd(5'd2, 32'h00, "press_rise_early");
        step(1);
        expect_rd(5'd1, 32'h01, "press_db");
        expect_rd(5'd2, 32'h00, "press_rise_pre");
        step(1);
        expect_rd(5'd2, 32'h01, "press_rise");
        step(3);
        expect_rd(5'd2, 32'h01, "press_rise_sticky");

        // Glitch: bit 1 high for 5 cycles must not reach db or rise
        din = 5'h03;
        step(2);
        expect_rd(5'd0, 32'h03, "glitch_sync_hi");
        step(3);
        din = 5'h01;
        for (int i = 0; i < 14; i++) begin
            step(1);
            expect_rd(5'd1, 32'h01, "glitch_db");
            expect_rd(5'd2, 32'h01, "glitch_rise");
        end
        expect_rd(5'd0, 32'h01, "glitch_sync_lo");

        // W1C: get rise = 0x03 then clear bit 0
        din = 5'h03;
        step(12);
        expect_rd(5'd1, 32'h03, "w1c_db");
        expect_rd(5'd2, 32'h03, "w1c_rise_pre");
        do_write(5'd2, 32'h1, 1'b1);
        expect_rd(5'd2, 32'h02, "w1c_rise_post");
        do_write(5'd1, 32'hFFFF_FFFF, 1'b1);
        expect_rd(5'd0, 32'h03, "ign_sync");
        expect_rd(5'd1, 32'h03, "ign_db");
        expect_rd(5'd2, 32'h02, "ign_rise");
        expect_rd(5'd3, 32'h00, "ign_fall");
        do_write(5'd2, 32'h2, 1'b0);
        expect_rd(5'd2, 32'h02, "nocs_rise");

        // Collision: W1C of bit 2 on the edge where rise[2] is set
        din = 5'h07;
        step(11);
        expect_rd(5'd1, 32'h07, "coll_db");
        expect_rd(5'd2, 32'h02, "coll_rise_pre");
        do_write(5'd2, 32'h4, 1'b1);
        expect_rd(5'd2, 32'h06, "coll_set_wins");
        do_write(5'd2, 32'h4, 1'b1);
        expect_rd(5'd2, 32'h02, "coll_clear_after");

        // Release bit 0: fall event only with the optional feature
        din = 5'h06;
        step(10);
        expect_rd(5'd1, 32'h07, "rel_db_early");
        step(1);
        expect_rd(5'd1, 32'h06, "rel_db");
        expect_rd(5'd3, 32'h00, "rel_fall_pre");
        step(1);
`ifdef DB_FALL_EDGE_EN
        expect_rd(5'd3, 32'h01, "rel_fall");
        do_write(5'd3, 32'h1, 1'b1);
        expect_rd(5'd3, 32'h00, "fall_w1c");
`else
        expect_rd(5'd3, 32'h00, "rel_fall_off");
        do_write(5'd3, 32'h1F, 1'b1);
        expect_rd(5'd3, 32'h00, "fall_off_wr");
`endif
        expect_rd(5'd2, 32'h02, "rel_rise_keep");

        // Reset in the middle of debouncing bit 3: no carry-over
        din = 5'h0E;
        step(6);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        for (int a = 0; a < 4; a++) expect_rd(5'(a), 32'h0, "midrst_zero");
        step(2);
        expect_rd(5'd0, 32'h0E, "midrst_sync");
        step(8);
        expect_rd(5'd1, 32'h00, "midrst_db_early");
        step(1);
        expect_rd(5'd1, 32'h0E, "midrst_db");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
